cab_led_display: RTL and testbench

- Downstream consumer of the MVS cabinet I/O latch outputs: EL select (3 bits plus latch) and two LED data buses (8 bits plus latch each).
- Captures each channel on the rising edge of its latch bit.
- Holds the captured values and drives a 4-digit multiplexed 7-segment credit display (two BCD digits per LED channel) plus a registered EL select output.
- Simulation/verification-board block clocked from the system 24 MHz clock.

---
 rtl/cab_led_display.sv | 157 +++++++++++++++
 tb/tb_cab_led_display.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cab_led_display.sv
// cab_led_display
// ----------------
// Receives the EL select and the two LED credit buses from the MVS cabinet
// I/O latches. It captures each channel when its latch strobe rises and
// drives a 4-digit multiplexed 7-segment credit display from the captured
// values. It also outputs the captured EL select as a registered value.
//
// Ports:
//   CLK_24M   in   system clock (24 MHz)
//   nRESET    in   asynchronous active-low reset
//   EL_OUT    in   [3] EL latch strobe, [2:0] EL data (async to CLK_24M)
//   LED_OUT1  in   [8] LED1 latch strobe, [7:0] BCD data (tens, ones)
//   LED_OUT2  in   [8] LED2 latch strobe, [7:0] BCD data (tens, ones)
//   EL_SEL    out  last captured EL data
//   SEG_n     out  segments {g,f,e,d,c,b,a}, active-low
//   DIG_n     out  digit enables, active-low:
//                  [0] LED1 tens, [1] LED1 ones, [2] LED2 tens, [3] LED2 ones
//   UPDATE    out  one-cycle capture pulses: [0] EL, [1] LED1, [2] LED2
module cab_led_display #(
    parameter int SCAN_DIV     = 12000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       CLK_24M,
    input  logic       nRESET,
    input  logic [3:0] EL_OUT,
    input  logic [8:0] LED_OUT1,
    input  logic [8:0] LED_OUT2,
    output logic [2:0] EL_SEL,
    output logic [6:0] SEG_n,
    output logic [3:0] DIG_n,
    output logic [2:0] UPDATE
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_BLNK = PW'(BLANK_CYCLES);

    // All asynchronous inputs are packed into one vector so that every bit
    // gets the same two-flop synchronizer.
    // Bit layout: [21] LED2 latch, [20:13] LED2 data, [12] LED1 latch,
    //             [11:4] LED1 data, [3] EL latch, [2:0] EL data.
    logic [21:0] sync1_q, sync2_q;
    logic [2:0]  latch_s;
    logic [2:0]  prev_q;
    logic [2:0]  rise_q;
    logic [18:0] hold_q;      // data that belongs to the edge in rise_q
    logic [2:0]  el_q;
    logic [7:0]  led1_q, led2_q;
    logic [2:0]  update_q;

    assign latch_s = {sync2_q[21], sync2_q[12], sync2_q[3]};

    // The capture runs in three stages: synchronize, detect the edge, store.
    // The edge flag and its data move together through hold_q. The store
    // therefore uses data from the cycle in which the edge was seen.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            rise_q   <= '0;
            hold_q   <= '0;
            el_q     <= '0;
            led1_q   <= 8'hFF;
            led2_q   <= 8'hFF;
            update_q <= '0;
        end else begin
            sync1_q  <= {LED_OUT2, LED_OUT1, EL_OUT};
            sync2_q  <= sync1_q;
            prev_q   <= latch_s;
            rise_q   <= latch_s & ~prev_q;
            hold_q   <= {sync2_q[20:13], sync2_q[11:4], sync2_q[2:0]};
            update_q <= rise_q;
            if (rise_q[0]) el_q   <= hold_q[2:0];
            if (rise_q[1]) led1_q <= hold_q[10:3];
            if (rise_q[2]) led2_q <= hold_q[18:11];
        end
    end

    assign EL_SEL = el_q;
    assign UPDATE = update_q;

    // Scan timing: one digit slot lasts SCAN_DIV cycles.
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 1'b1;
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;   // non-BCD nibbles show as blank
        endcase
        return s;
    endfunction

    logic [3:0] nib;
    logic       tens_zero;
    logic [6:0] seg_d;
    logic [3:0] dig_d;

    always_comb begin
        case (idx_q)
            2'd0:    nib = led1_q[7:4];
            2'd1:    nib = led1_q[3:0];
            2'd2:    nib = led2_q[7:4];
            default: nib = led2_q[3:0];
        endcase
        // Leading-zero blanking applies only to the tens digits (even indices).
        tens_zero = (idx_q[0] == 1'b0) && (nib == 4'd0);
        if (presc_q < PRESC_BLNK) begin
            dig_d = 4'hF;
            seg_d = 7'h7F;
        end else begin
            dig_d = ~(4'b0001 << idx_q);
            seg_d = tens_zero ? 7'h7F : seg_decode(nib);
        end
    end

    logic [6:0] seg_q;
    logic [3:0] dig_q;

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h7F;
            dig_q   <= 4'hF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign SEG_n = seg_q;
    assign DIG_n = dig_q;

endmodule

// File: tb/tb_cab_led_display.sv
module tb_cab_led_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] el;
    logic [8:0] l1, l2;
    logic [2:0] el_sel;
    logic [6:0] seg;
    logic [3:0] dig;
    logic [2:0] upd;

    int total = 0;
    int bad   = 0;

    cab_led_display #(
        .SCAN_DIV    (8),
        .BLANK_CYCLES(2)
    ) dut (
        .CLK_24M (clk),
        .nRESET  (rst_n),
        .EL_OUT  (el),
        .LED_OUT1(l1),
        .LED_OUT2(l2),
        .EL_SEL  (el_sel),
        .SEG_n   (seg),
        .DIG_n   (dig),
        .UPDATE  (upd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until DIG_n shows the requested pattern (bounded).
    task automatic wait_dig(input logic [3:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (dig === want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0;
        el = 4'h0; l1 = 9'h000; l2 = 9'h000;
        repeat (10) tick();
        total++;
        if (seg !== 7'h7F || dig !== 4'hF || el_sel !== 3'd0 || upd !== 3'd0) begin
            bad++;
            $display("FAIL reset_hold: seg=%h dig=%h el_sel=%0d upd=%b, want 7f f 0 000", seg, dig, el_sel, upd);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (seg !== 7'h7F || dig !== 4'hF || el_sel !== 3'd0 || upd !== 3'd0) begin
            bad++;
            $display("FAIL reset_release: seg=%h dig=%h el_sel=%0d upd=%b, want 7f f 0 000", seg, dig, el_sel, upd);
        end
        wait_dig(4'hE, ok);
        total++;
        if (!ok || seg !== 7'h7F) begin
            bad++;
            $display("FAIL reset_first_digit: ok=%0d seg=%h, want 1 7f", ok, seg);
        end
        $display("test_reset: seg=%h dig=%h", seg, dig);
    endtask

    task automatic test_led1_capture();
        bit ok;
        int pulses;
        logic [2:0] exp_upd;
        l1 = 9'h042;
        repeat (3) tick();
        l1 = 9'h142;              // the next edge is the first one to sample the latch high
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp_upd = (c == 3'd4) ? 3'b010 : 3'b000;
            total++;
            if (upd !== exp_upd) begin
                bad++;
                $display("FAIL led1_update_c%0d: upd=%b want %b", c, upd, exp_upd);
            end
        end
        // The latch stays high and the data changes. There must be no further capture.
        l1 = 9'h199;
        pulses = 0;
        repeat (100) begin
            tick();
            if (upd[1]) pulses++;
        end
        l1 = 9'h099;              // falling edge
        repeat (10) begin
            tick();
            if (upd[1]) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL led1_held_latch: extra pulses=%0d want 0", pulses);
        end
        wait_dig(4'hE, ok);
        total++;
        if (!ok || seg !== 7'h19) begin
            bad++;
            $display("FAIL led1_tens: ok=%0d seg=%h want 19", ok, seg);
        end
        wait_dig(4'hD, ok);
        total++;
        if (!ok || seg !== 7'h24) begin
            bad++;
            $display("FAIL led1_ones: ok=%0d seg=%h want 24", ok, seg);
        end
        $display("test_led1_capture: pulses_after=%0d seg=%h", pulses, seg);
    endtask

    task automatic test_simultaneous();
        bit ok;
        el = 4'h5; l1 = 9'h007; l2 = 9'h01A;
        repeat (3) tick();
        el = 4'hD; l1 = 9'h107; l2 = 9'h11A;
        repeat (3) tick();
        total++;
        if (upd !== 3'b000 || el_sel !== 3'd0) begin
            bad++;
            $display("FAIL sim_early: upd=%b el_sel=%0d want 000 0", upd, el_sel);
        end
        tick();
        total++;
        if (upd !== 3'b111 || el_sel !== 3'd5) begin
            bad++;
            $display("FAIL sim_capture: upd=%b el_sel=%0d want 111 5", upd, el_sel);
        end
        tick();
        total++;
        if (upd !== 3'b000) begin
            bad++;
            $display("FAIL sim_pulse_width: upd=%b want 000", upd);
        end
        el = 4'h5; l1 = 9'h007; l2 = 9'h01A;
        wait_dig(4'hE, ok);
        total++;
        if (!ok || seg !== 7'h7F) begin
            bad++;
            $display("FAIL sim_led1_tens: ok=%0d seg=%h want 7f", ok, seg);
        end
        wait_dig(4'hD, ok);
        total++;
        if (!ok || seg !== 7'h78) begin
            bad++;
            $display("FAIL sim_led1_ones: ok=%0d seg=%h want 78", ok, seg);
        end
        wait_dig(4'hB, ok);
        total++;
        if (!ok || seg !== 7'h79) begin
            bad++;
            $display("FAIL sim_led2_tens: ok=%0d seg=%h want 79", ok, seg);
        end
        wait_dig(4'h7, ok);
        total++;
        if (!ok || seg !== 7'h7F) begin
            bad++;
            $display("FAIL sim_led2_ones: ok=%0d seg=%h want 7f", ok, seg);
        end
        $display("test_simultaneous: el_sel=%0d", el_sel);
    endtask

    task automatic test_scan_wrap();
        bit ok, ok2;
        int pos, slot, errs;
        logic [3:0] exp_dig;
        wait_dig(4'hF, ok);
        wait_dig(4'hE, ok2);       // first active cycle of slot 0 (position 2)
        total++;
        if (!ok || !ok2) begin
            bad++;
            $display("FAIL scan_sync: ok=%0d ok2=%0d want 1 1", ok, ok2);
        end
        errs = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            pos  = (2 + k) % 8;
            slot = ((2 + k) / 8) % 4;
            exp_dig = (pos < 2) ? 4'hF : ~(4'b0001 << slot);
            total++;
            if (dig !== exp_dig) begin
                bad++;
                errs++;
                $display("FAIL scan_k%0d: dig=%h want %h", k, dig, exp_dig);
            end
        end
        $display("test_scan_wrap: errors=%0d", errs);
    endtask

    task automatic test_reset_midscan();
        bit ok;
        l2 = 9'h155;
        repeat (6) tick();
        l2 = 9'h055;
        wait_dig(4'hB, ok);
        total++;
        if (!ok || seg !== 7'h12) begin
            bad++;
            $display("FAIL mid_led2_before: ok=%0d seg=%h want 12", ok, seg);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (seg !== 7'h7F || dig !== 4'hF || el_sel !== 3'd0 || upd !== 3'd0) begin
            bad++;
            $display("FAIL mid_async_reset: seg=%h dig=%h el_sel=%0d upd=%b want 7f f 0 000", seg, dig, el_sel, upd);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (dig !== 4'hF) begin
            bad++;
            $display("FAIL mid_blank_after: dig=%h want f", dig);
        end
        tick();
        total++;
        if (dig !== 4'hE || seg !== 7'h7F) begin
            bad++;
            $display("FAIL mid_index_restart: dig=%h seg=%h want e 7f", dig, seg);
        end
        wait_dig(4'hB, ok);
        total++;
        if (!ok || seg !== 7'h7F) begin
            bad++;
            $display("FAIL mid_led2_blank: ok=%0d seg=%h want 7f", ok, seg);
        end
        wait_dig(4'h7, ok);
        total++;
        if (!ok || seg !== 7'h7F || el_sel !== 3'd0) begin
            bad++;
            $display("FAIL mid_led2_ones_blank: ok=%0d seg=%h el_sel=%0d want 7f 0", ok, seg, el_sel);
        end
        $display("test_reset_midscan: seg=%h dig=%h", seg, dig);
    endtask

    initial begin
        test_reset();
        test_led1_capture();
        test_simultaneous();
        test_scan_wrap();
        test_reset_midscan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
